// File: rtl/gpu_mem_pkg.sv
// Shared types and sizes for the pixel/texture SRAM path.
package gpu_mem_pkg;
   localparam int SRAM_AW = 11;
   localparam int SRAM_DW = 8;

   typedef enum logic [1:0] {
      GNT_NONE,
      GNT_RD,
      GNT_WR
   } gnt_t;
endpackage

// File: rtl/sram_wr_fifo.sv
// Posted-write FIFO in front of the SRAM: in-order drain plus a parallel
// address match across all live entries for read-after-write checking.
module sram_wr_fifo
   import gpu_mem_pkg::*;
#(
   parameter int AW    = SRAM_AW,
   parameter int DW    = SRAM_DW,
   parameter int DEPTH = 2
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push,
   input  logic [AW-1:0] push_addr,
   input  logic [DW-1:0] push_data,
   input  logic          pop,
   output logic          empty,
   output logic          full,
   output logic [AW-1:0] head_addr,
   output logic [DW-1:0] head_data,
   input  logic [AW-1:0] match_addr,
   output logic          match
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [AW-1:0]    addr_q [DEPTH];
   logic [DW-1:0]    data_q [DEPTH];
   logic [DEPTH-1:0] vld_q;
   logic [PW-1:0]    wr_ptr_q;
   logic [PW-1:0]    rd_ptr_q;
   logic [CW-1:0]    cnt_q;
   logic             push_ok;
   logic             pop_ok;

   assign empty     = (cnt_q == '0);
   assign full      = (cnt_q == CW'(DEPTH));
   assign push_ok   = push && !full;
   assign pop_ok    = pop && !empty;
   assign head_addr = addr_q[rd_ptr_q];
   assign head_data = data_q[rd_ptr_q];

   // Per-entry valid bits let the hazard compare ignore stale slots.
   always_comb begin
      match = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (vld_q[i] && (addr_q[i] == match_addr)) match = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            addr_q[i] <= '0;
            data_q[i] <= '0;
         end
         vld_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (push_ok) begin
            addr_q[wr_ptr_q] <= push_addr;
            data_q[wr_ptr_q] <= push_data;
            vld_q[wr_ptr_q]  <= 1'b1;
            wr_ptr_q         <= wr_ptr_q + PW'(1);
         end
         if (pop_ok) begin
            vld_q[rd_ptr_q] <= 1'b0;
            rd_ptr_q        <= rd_ptr_q + PW'(1);
         end
         case ({push_ok, pop_ok})
            2'b10:   cnt_q <= cnt_q + CW'(1);
            2'b01:   cnt_q <= cnt_q - CW'(1);
            default: cnt_q <= cnt_q;
         endcase
      end
   end

endmodule

// File: rtl/sram_arbiter.sv
// Single-port SRAM arbiter: texel reads vs. posted loader writes, read
// priority during scan-out with a bounded write wait, round-robin in blanking.
module sram_arbiter
   import gpu_mem_pkg::*;
#(
   parameter int AW       = SRAM_AW,
   parameter int DW       = SRAM_DW,
   parameter int WF_DEPTH = 2,
   parameter int MAX_WAIT = 15
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          active,
   input  logic          wr_valid,
   output logic          wr_ready,
   input  logic [AW-1:0] wr_addr,
   input  logic [DW-1:0] wr_data,
   input  logic          rd_valid,
   output logic          rd_ready,
   input  logic [AW-1:0] rd_addr,
   output logic          rd_rvalid,
   output logic [DW-1:0] rd_rdata,
   output logic          sram_cen,
   output logic          sram_wen,
   output logic [AW-1:0] sram_addr,
   output logic [DW-1:0] sram_din,
   input  logic [DW-1:0] sram_dout,
   output logic          busy
);

   localparam logic [7:0] WAIT_MAX = 8'(MAX_WAIT);

   logic          init_q;
   logic [7:0]    wait_cnt_q;
   logic          fav_wr_q;
   logic          rvalid_q;
   gnt_t          gnt;
   logic          wf_empty;
   logic          wf_full;
   logic [AW-1:0] head_addr;
   logic [DW-1:0] head_data;
   logic          hazard;
   logic          rd_elig;
   logic          wr_elig;
   logic          wf_push;
   logic          forced_wr;

   sram_wr_fifo #(
      .AW    (AW),
      .DW    (DW),
      .DEPTH (WF_DEPTH)
   ) u_wr_fifo (
      .clk        (clk),
      .rst_n      (rst_n),
      .push       (wf_push),
      .push_addr  (wr_addr),
      .push_data  (wr_data),
      .pop        (gnt == GNT_WR),
      .empty      (wf_empty),
      .full       (wf_full),
      .head_addr  (head_addr),
      .head_data  (head_data),
      .match_addr (rd_addr),
      .match      (hazard)
   );

   // init_q keeps both ports closed until the first edge after reset release.
   assign wr_ready  = init_q && !wf_full;
   assign wf_push   = wr_valid && wr_ready;
   assign rd_elig   = init_q && rd_valid && !hazard;
   assign wr_elig   = init_q && !wf_empty;
   assign forced_wr = wr_elig && (wait_cnt_q == WAIT_MAX);

   always_comb begin
      gnt = GNT_NONE;
      if (active) begin
         if (rd_elig && !forced_wr) gnt = GNT_RD;
         else if (wr_elig)          gnt = GNT_WR;
      end else if (rd_elig && wr_elig) begin
         gnt = fav_wr_q ? GNT_WR : GNT_RD;
      end else if (rd_elig) begin
         gnt = GNT_RD;
      end else if (wr_elig) begin
         gnt = GNT_WR;
      end
   end

   always_comb begin
      sram_addr = '0;
      sram_din  = '0;
      case (gnt)
         GNT_RD: sram_addr = rd_addr;
         GNT_WR: begin
            sram_addr = head_addr;
            sram_din  = head_data;
         end
         default: ;
      endcase
   end

   assign rd_ready  = (gnt == GNT_RD);
   assign sram_cen  = (gnt == GNT_NONE);
   assign sram_wen  = (gnt != GNT_WR);
   assign rd_rvalid = rvalid_q;
   assign rd_rdata  = sram_dout;
   assign busy      = !wf_empty || rvalid_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         init_q     <= 1'b0;
         wait_cnt_q <= '0;
         fav_wr_q   <= 1'b1;
         rvalid_q   <= 1'b0;
      end else begin
         init_q   <= 1'b1;
         rvalid_q <= (gnt == GNT_RD);
         if (wf_empty || gnt == GNT_WR)  wait_cnt_q <= '0;
         else if (wait_cnt_q != WAIT_MAX) wait_cnt_q <= wait_cnt_q + 8'd1;
         if (!active && rd_elig && wr_elig) fav_wr_q <= !fav_wr_q;
      end
   end

endmodule
